// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and default sizing for the boot loader
package loader_pkg;

  localparam int ADDR_W_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/uart_imem_loader_if.sv
// rtl/uart_imem_loader_if.sv - received-byte stream in, instruction-memory write port out
interface uart_imem_loader_if
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  logic [7:0]        uart_serial;
  logic              rx_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // master: UART receiver / memory side; slave: the loader itself
  modport master (
    output uart_serial, rx_valid,
    input  imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  uart_serial, rx_valid,
    output imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - length-prefixed UART image loader into instruction memory
module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flash,
  uart_imem_loader_if.slave    bus,
  output logic                 core_hold,
  output logic                 done,
  output logic                 error
);

  localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

  loader_state_t     state_q, state_d;
  logic              flash_q;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [31:0]       len_q, len_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;

  logic              flash_rise, flash_fall, byte_last;
  logic [31:0]       word;
  logic [ADDR_W:0]   wcnt_inc;

  always_comb begin
    flash_rise   = flash & ~flash_q;
    flash_fall   = ~flash & flash_q;
    byte_last    = bus.rx_valid && (bcnt_q == 2'd3);
    word         = {bus.uart_serial, shift_q};
    wcnt_inc     = wcnt_q + 1'b1;

    state_d      = state_q;
    bcnt_d       = bcnt_q;
    wcnt_d       = wcnt_q;
    shift_d      = shift_q;
    len_d        = len_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        // a byte arriving with the flash edge is dropped: counters restart from zero
        if (flash_rise) begin
          state_d = LEN;
          bcnt_d  = '0;
          wcnt_d  = '0;
          shift_d = '0;
          len_d   = '0;
        end
      end
      LEN: begin
        if (bus.rx_valid) begin
          shift_d = {bus.uart_serial, shift_q[23:8]};
          bcnt_d  = bcnt_q + 2'd1;
        end
        if (byte_last) begin
          len_d = word;
          if (word == 32'd0)                state_d = DONE;
          else if ({1'b0, word} > DEPTH)    state_d = ERR;
          else                              state_d = DATA;
        end
        if (flash_fall) state_d = ERR;
      end
      DATA: begin
        if (bus.rx_valid) begin
          shift_d = {bus.uart_serial, shift_q[23:8]};
          bcnt_d  = bcnt_q + 2'd1;
        end
        // a word completing on the abort edge is still written
        if (byte_last) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = wcnt_q[ADDR_W-1:0];
          imem_wdata_d = word;
          wcnt_d       = wcnt_inc;
          if (32'(wcnt_inc) == len_q) state_d = DONE;
        end
        if (flash_fall) state_d = ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      flash_q      <= 1'b0;
      bcnt_q       <= '0;
      wcnt_q       <= '0;
      shift_q      <= '0;
      len_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      flash_q      <= flash;
      bcnt_q       <= bcnt_d;
      wcnt_q       <= wcnt_d;
      shift_q      <= shift_d;
      len_q        <= len_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign core_hold      = (state_q == LEN) || (state_q == DATA);
  assign done           = (state_q == DONE);
  assign error          = (state_q == ERR);

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb/tb_uart_imem_loader.sv - directed vector and sequence bench for uart_imem_loader
module tb_uart_imem_loader;
  import loader_pkg::*;

  localparam int AW = 4;

  typedef struct {
    logic        flash;
    logic        rv;
    logic [7:0]  b;
    logic        we;
    logic        hold;
    logic        dn;
    logic        er;
    logic [AW-1:0] addr;
    logic [31:0] data;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flash = 1'b0;
  logic core_hold, done, error;
  int   checks = 0;
  int   failures = 0;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  vec_t          tbl[$];

  uart_imem_loader_if #(.ADDR_W(AW)) bus ();

  uart_imem_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flash     (flash),
    .bus       (bus),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && bus.imem_we) begin
      log_addr.push_back(bus.imem_addr);
      log_data.push_back(bus.imem_wdata);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.uart_serial = b;
    bus.rx_valid    = 1'b1;
    step();
    bus.rx_valid    = 1'b0;
  endtask

  function automatic vec_t mk(input logic f, input logic rv, input logic [7:0] b,
                              input logic we, input logic hold, input logic dn, input logic er,
                              input logic [AW-1:0] a, input logic [31:0] d);
    vec_t v;
    v.flash = f; v.rv = rv; v.b = b; v.we = we; v.hold = hold;
    v.dn = dn; v.er = er; v.addr = a; v.data = d;
    return v;
  endfunction

  task automatic load3(input bit sparse);
    logic [31:0] w [3];
    w[0] = 32'h00100513; w[1] = 32'h00200593; w[2] = 32'hdeadbeef;
    log_addr.delete(); log_data.delete();
    flash = 1'b0; step();
    flash = 1'b1; step();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (sparse) repeat ($urandom_range(0, 19)) step();
        send_byte(w[i][8*k +: 8]);
      end
    end
    step(); step();
    chk(sparse ? "sparse_nwrites" : "full_nwrites", 64'(log_addr.size()), 64'd3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      chk(sparse ? "sparse_addr" : "full_addr", 64'(log_addr[i]), 64'(i));
      chk(sparse ? "sparse_data" : "full_data", 64'(log_data[i]), 64'(w[i]));
    end
    chk("load3_done", 64'({core_hold, done, error}), 64'b010);
  endtask

  initial begin
    bus.uart_serial = 8'h00;
    bus.rx_valid    = 1'b0;

    #12;
    chk("reset_outputs", {27'd0, bus.imem_we, bus.imem_addr, core_hold, done, error},
        64'd0);
    chk("reset_wdata", 64'(bus.imem_wdata), 64'd0);
    step();
    rst = 1'b1;
    step();

    // two-word load
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h02, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h13, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h05, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h10, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h00, 1, 1, 0, 0, 0, 32'h00100513));
    tbl.push_back(mk(1, 1, 8'h93, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h05, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h20, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h00, 1, 0, 1, 0, 1, 32'h00200593));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
    // zero length; the byte on the flash edge must be dropped
    tbl.push_back(mk(1, 1, 8'h77, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h00, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
    // overlength: 17 > 16 words
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h11, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h00, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 1, 8'haa, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      flash           = tbl[i].flash;
      bus.rx_valid    = tbl[i].rv;
      bus.uart_serial = tbl[i].b;
      step();
      chk($sformatf("vec%0d_status", i), 64'({bus.imem_we, core_hold, done, error}),
          64'({tbl[i].we, tbl[i].hold, tbl[i].dn, tbl[i].er}));
      if (tbl[i].we) begin
        chk($sformatf("vec%0d_addr", i), 64'(bus.imem_addr), 64'(tbl[i].addr));
        chk($sformatf("vec%0d_data", i), 64'(bus.imem_wdata), 64'(tbl[i].data));
      end
    end
    bus.rx_valid = 1'b0;

    // abort after 6 data bytes
    log_addr.delete(); log_data.delete();
    flash = 1'b1; step();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    flash = 1'b0; step();
    repeat (3) step();
    chk("abort_nwrites", 64'(log_addr.size()), 64'd1);
    if (log_addr.size() > 0) begin
      chk("abort_addr", 64'(log_addr[0]), 64'd0);
      chk("abort_data", 64'(log_data[0]), 64'h04030201);
    end
    chk("abort_status", 64'({core_hold, done, error}), 64'b001);

    // reset mid-word, then reload
    log_addr.delete(); log_data.delete();
    flash = 1'b1; step();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    rst = 1'b0; flash = 1'b0;
    #1;
    chk("rst_mid_outputs", {27'd0, bus.imem_we, bus.imem_addr, core_hold, done, error},
        64'd0);
    chk("rst_mid_wdata", 64'(bus.imem_wdata), 64'd0);
    step(); step();
    rst = 1'b1; step();
    chk("rst_mid_nowrite", 64'(log_addr.size()), 64'd0);
    flash = 1'b1; step();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'haa); send_byte(8'hbb); send_byte(8'hcc); send_byte(8'hdd);
    step();
    chk("reload_nwrites", 64'(log_addr.size()), 64'd1);
    if (log_addr.size() > 0) begin
      chk("reload_addr", 64'(log_addr[0]), 64'd0);
      chk("reload_data", 64'(log_data[0]), 64'hddccbbaa);
    end
    chk("reload_done", 64'({core_hold, done, error}), 64'b010);

    // full-rate vs sparse three-word loads, then stray bytes in DONE
    load3(1'b0);
    load3(1'b1);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h40 + i));
    step();
    chk("done_stray_nwrites", 64'(log_addr.size()), 64'd3);
    chk("done_stray_status", 64'({core_hold, done, error}), 64'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_imem_loader.md
# uart_imem_loader

Boot loader between the UART byte receiver and the instruction memory of `top`. While `flash` is high it takes a length-prefixed little-endian byte stream from `uart_serial` and assembles it into 32-bit words. It writes those words to consecutive instruction-memory addresses and holds the core in reset until the image is complete.

## Interface
Parameters:
- `ADDR_W`, default 10: instruction-memory word-address width. Depth is `2**ADDR_W` words.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flash`  in  1  load-mode request, level; a rising edge starts a load.
- `uart_serial`  in  8  received byte.
- `rx_valid`  in  1  `uart_serial` holds a new byte this cycle. Single-cycle strobe; may be high on consecutive cycles.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  `ADDR_W`  word address.
- `imem_wdata`  out  32  word to write.
- `core_hold`  out  1  holds the CPU in reset.
- `done`  out  1  last load completed successfully.
- `error`  out  1  last load aborted.

## Operation
- FSM states: `IDLE`, `LEN`, `DATA`, `DONE`, `ERR`.
- `IDLE`/`DONE`/`ERR` → `LEN` on the `flash` rising edge. Edge is detected against a registered copy of `flash`.
  - On entry, clear `done`, `error`, the byte counter, the word counter and the shift register.
- `LEN`: take 4 bytes, LSB first, into `len[31:0]`.
  - After the 4th byte: if `len == 0`, go to `DONE`.
  - If `len > 2**ADDR_W`, go to `ERR`.
  - Otherwise go to `DATA`.
- `DATA`: take bytes LSB first. Each 4th byte completes a word, which is written at address `wcnt`; then `wcnt` increments.
  - When `wcnt+1 == len`, go to `DONE` on the same edge as the 4th byte.
- `DONE`: `done=1`. Bytes are ignored.
- `ERR`: `error=1`. Bytes are ignored.
- `flash` falling while in `LEN`/`DATA`: abort to `ERR`. A word that completes on that same edge is still written. Already-written words stay in memory.
- `rx_valid` while in `IDLE`/`DONE`/`ERR`: byte discarded.
- `flash` rising and `rx_valid` on the same edge: the byte is discarded. The first counted byte is the next strobe.
- `core_hold = 1` exactly when the state is `LEN` or `DATA`.
- Byte counter: 2 bits, wraps 3→0. Word counter: `ADDR_W+1` bits so the full-depth case does not wrap. Comparison with `len` is zero-extended.

## Timing
- Reset values (asynchronous): state `IDLE`, `imem_we=0`, `imem_addr=0`, `imem_wdata=0`, `core_hold=0`, `done=0`, `error=0`, `flash` history `0`.
  - Reset mid-load returns to `IDLE` immediately; no write is issued.
- Write latency:
  - `imem_we` pulses for exactly one cycle in the cycle after the edge that accepts the 4th byte of a word.
  - `imem_addr` and `imem_wdata` are registered and valid in that cycle.
  - `imem_wdata = {b3,b2,b1,b0}`.
- No backpressure. A full-rate stream (`rx_valid` every cycle) sustains one write per 4 cycles.
- `core_hold` rises 1 cycle after the `flash` rising edge (registered edge detect plus state register). It falls on the cycle the state becomes `DONE`, which is the same cycle as the final `imem_we`.
- `done` and `error` are registered state decodes. They hold until the next load starts.

## Structure
- Shared package `loader_pkg`: state enum `loader_state_t` and the `ADDR_W` default constant, so `top` and the benches can reuse them.
- Single module, no sub-module. A shared byte-assembler is not worth splitting out.
- `top` instantiates this block between the UART receiver and the instruction-memory write port. It ORs `core_hold` into the core reset.

## Test plan
- Load 2 words. Stimulus: `flash` 0→1, then bytes `02 00 00 00 | 13 05 10 00 | 93 05 20 00` back-to-back, one per cycle. Required:
  - `imem_we` pulses at addr 0 with `0x00100513`, then at addr 1 with `0x00200593`.
  - `done=1`; `core_hold` falls with the 2nd write.
- Zero length. Stimulus: bytes `00 00 00 00`. Required: `DONE` with no `imem_we`; `core_hold` high only during `LEN`.
- Overlength with `ADDR_W=4`. Stimulus: `len=17`. Required: `error=1`, no writes, later bytes ignored.
- Abort. Stimulus: `flash` drops after 6 data bytes. Required: word 0 written, no write for the partial word, `error=1`, `core_hold=0`.
- Reset mid-word. Stimulus: `rst=0` after 2 data bytes, then a reload. Required:
  - All outputs return to their reset values and no write occurs.
  - The reload starts from addr 0 with a fresh byte phase.
- Sparse and stray strobes. Stimulus:
  - `rx_valid` at random gaps of 1–20 cycles during a 3-word load: required to produce identical writes to the full-rate case.
  - Bytes sent in `DONE`: required to cause no writes.
